axi_slave_write_ctrl: RTL and testbench

AXI3 write-path slave endpoint that sits directly downstream of the interconnect's slave-side write channels (AW/W/B of S0 or S1).
- Accepts one write address, then the matching data burst (FIXED/INCR/WRAP), and drives a single-port SRAM-style write interface per beat.
- Returns one B response per burst.
- Handles one outstanding transaction at a time (no AW/W interleaving).

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_burst_addr_gen.sv | 20 ++
 rtl/axi_slave_write_ctrl.sv | 101 ++++++++++
 tb/tb_axi_slave_write_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI types, width constants and slave write-path states
package axi_pkg;
  localparam int AXI_ID_BITS = 4;
  localparam int AXI_IDS_BITS = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
  localparam int AXI_LEN_BITS = 4;
  localparam int AXI_SIZE_BITS = 3;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} burst_t;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen import axi_pkg::*; #(
  parameter int ADDR_W = AXI_ADDR_BITS,
  parameter int LEN_W = AXI_LEN_BITS
) (
  input  logic [ADDR_W-1:0]        cur_addr,
  input  logic [AXI_SIZE_BITS-1:0] size,
  input  logic [LEN_W-1:0]         len,
  input  burst_t                   burst,
  output logic [ADDR_W-1:0]        next_addr
);
  logic [ADDR_W-1:0] step, mask;
  always_comb begin
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    next_addr = burst == BURST_FIXED ? cur_addr :
                burst == BURST_WRAP ? (cur_addr & ~mask) | ((cur_addr + step) & mask) :
                cur_addr + step;
  end
endmodule

// File: rtl/axi_slave_write_ctrl.sv
// axi_slave_write_ctrl: single-outstanding AXI3 write slave driving an SRAM-style port
module axi_slave_write_ctrl import axi_pkg::*; #(
  parameter int ID_W = AXI_IDS_BITS,
  parameter int ADDR_W = AXI_ADDR_BITS,
  parameter int DATA_W = AXI_DATA_BITS,
  parameter int LEN_W = AXI_LEN_BITS,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0001_0000,
  parameter logic [ADDR_W-1:0] RANGE_BYTES = 'h0001_0000,
  parameter int STRB_W = DATA_W / 8,
  parameter int MEM_AW = $clog2(RANGE_BYTES / STRB_W)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_be
);
  localparam int SZ_MAX = $clog2(STRB_W);
  localparam logic [ADDR_W:0] LIM = {1'b0, BASE_ADDR} + {1'b0, RANGE_BYTES};
  wr_state_t state, state_n;
  logic [ID_W-1:0] id_q;
  logic [ADDR_W-1:0] addr_q, addr_n, step;
  logic [LEN_W-1:0] len_q;
  logic [2:0] size_q;
  burst_t burst_q;
  logic [LEN_W:0] cnt;
  resp_t err_q, aw_err;
  logic [ADDR_W:0] aw_end;
  logic aw_hs, w_hs, last, wrap_len_bad;
  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_gen (
    .cur_addr(addr_q), .size(size_q), .len(len_q), .burst(burst_q), .next_addr(addr_n)
  );
  // aw_end is one past the last byte touched, one bit wider so the window end cannot wrap
  always_comb begin
    step = ADDR_W'(1) << AWSIZE;
    aw_end = AWBURST == BURST_FIXED ? {1'b0, AWADDR} + {1'b0, step} :
             {1'b0, AWADDR} + (((ADDR_W+1)'(AWLEN) + (ADDR_W+1)'(1)) << AWSIZE);
    wrap_len_bad = AWLEN == '0 || (AWLEN & (AWLEN + LEN_W'(1))) != '0;
    aw_err = (AWADDR < BASE_ADDR || aw_end > LIM) ? RESP_DECERR :
             (AWSIZE > 3'(SZ_MAX) || AWBURST == BURST_RSVD ||
              (AWBURST == BURST_WRAP && (wrap_len_bad || (AWADDR & (step - ADDR_W'(1))) != '0))) ? RESP_SLVERR :
             RESP_OKAY;
    last = cnt == {1'b0, len_q};
    AWREADY = !ARESET && state == WR_IDLE;
    WREADY = !ARESET && state == WR_DATA;
    BVALID = !ARESET && state == WR_RESP;
    aw_hs = AWVALID && AWREADY;
    w_hs = WVALID && WREADY;
    mem_we = w_hs && err_q == RESP_OKAY;
    mem_addr = MEM_AW'((addr_q - BASE_ADDR) >> SZ_MAX);
    mem_wdata = WDATA;
    mem_be = WSTRB;
    BID = id_q;
    BRESP = err_q;
    state_n = state == WR_IDLE ? (aw_hs ? WR_DATA : WR_IDLE) :
              state == WR_DATA ? (w_hs && (WLAST || last) ? WR_RESP : WR_DATA) :
              (BREADY ? WR_IDLE : WR_RESP);
  end
  always_ff @(posedge ACLK) state <= ARESET ? WR_IDLE : state_n;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= BURST_FIXED;
      cnt <= '0;
      err_q <= RESP_OKAY;
    end else if (aw_hs) begin
      id_q <= AWID;
      addr_q <= AWADDR;
      len_q <= AWLEN;
      size_q <= AWSIZE;
      burst_q <= burst_t'(AWBURST);
      cnt <= '0;
      err_q <= aw_err;
    end else if (w_hs) begin
      cnt <= cnt + (LEN_W+1)'(1);
      addr_q <= addr_n;
      // a WLAST that disagrees with the beat count downgrades an otherwise clean burst
      if (WLAST != last && err_q == RESP_OKAY) err_q <= RESP_SLVERR;
    end
  end
endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// tb_axi_slave_write_ctrl: table-driven bursts plus hand-written protocol corner cases
module tb_axi_slave_write_ctrl;
  logic ACLK = 0, ARESET = 1;
  logic [7:0] AWID = 0;
  logic [31:0] AWADDR = 0;
  logic [3:0] AWLEN = 0;
  logic [2:0] AWSIZE = 0;
  logic [1:0] AWBURST = 0;
  logic AWVALID = 0, AWREADY;
  logic [31:0] WDATA = 0;
  logic [3:0] WSTRB = 0;
  logic WLAST = 0, WVALID = 0, WREADY;
  logic [7:0] BID;
  logic [1:0] BRESP;
  logic BVALID, BREADY = 0;
  logic mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  logic [13:0] wq[$];
  typedef struct {
    logic [7:0] id;
    logic [31:0] addr;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [1:0] resp;
    int nwr;
    logic [13:0] a[4];
  } vec_t;
  vec_t tbl[12];
  axi_slave_write_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );
  always #5 ACLK = ~ACLK;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1;
    #1;
    while (!AWREADY && n < 40) begin @(negedge ACLK); #1; n++; end
    check("awready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1;
    #1;
    while (!WREADY && n < 40) begin @(negedge ACLK); #1; n++; end
    check("wready", WREADY, 1);
    if (mem_we) begin
      wq.push_back(mem_addr);
      check("mem_wdata", mem_wdata, d);
      check("mem_be", mem_be, s);
    end
    @(negedge ACLK);
    WVALID = 0; WLAST = 0;
  endtask
  task automatic get_b(input logic [7:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    BREADY = 0;
    #1;
    while (!BVALID && n < 40) begin @(negedge ACLK); #1; n++; end
    check("bvalid", BVALID, 1);
    check("awready_in_resp", AWREADY, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK); #1;
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", BID, id);
      check("bresp_hold", BRESP, resp);
    end
    BREADY = 1;
    check("bid", BID, id);
    check("bresp", BRESP, resp);
    @(negedge ACLK);
    BREADY = 0;
    #1;
    check("bvalid_drop", BVALID, 0);
    check("awready_turnaround", AWREADY, 1);
  endtask
  task automatic check_writes(input int nwr, input logic [13:0] a[4]);
    check("wr_count", wq.size(), nwr);
    for (int i = 0; i < nwr; i++) check("wr_addr", i < wq.size() ? wq[i] : 14'bx, a[i]);
  endtask
  task automatic run_burst(input vec_t v);
    wq.delete();
    send_aw(v.id, v.addr, v.len, v.size, v.burst);
    for (int i = 0; i <= int'(v.len); i++) send_w(32'hA0 + i, 4'hF >> (3 - i % 4), i == int'(v.len));
    get_b(v.id, v.resp, 0);
    check_writes(v.nwr, v.a);
  endtask
  initial begin
    logic [13:0] ea[4];
    tbl[0]  = '{8'h5A, 32'h0001_0010, 4'd3, 3'd2, 2'b01, 2'b00, 4, '{14'h4, 14'h5, 14'h6, 14'h7}};
    tbl[1]  = '{8'h61, 32'h0001_0038, 4'd3, 3'd2, 2'b10, 2'b00, 4, '{14'hE, 14'hF, 14'hC, 14'hD}};
    tbl[2]  = '{8'h62, 32'h0002_0000, 4'd1, 3'd2, 2'b01, 2'b11, 0, '{default: 0}};
    tbl[3]  = '{8'h63, 32'h0001_FFF0, 4'd3, 3'd2, 2'b01, 2'b00, 4, '{14'h3FFC, 14'h3FFD, 14'h3FFE, 14'h3FFF}};
    tbl[4]  = '{8'h64, 32'h0001_FFF8, 4'd3, 3'd2, 2'b01, 2'b11, 0, '{default: 0}};
    tbl[5]  = '{8'h65, 32'h0000_FFFC, 4'd0, 3'd2, 2'b01, 2'b11, 0, '{default: 0}};
    tbl[6]  = '{8'h66, 32'h0001_0000, 4'd1, 3'd3, 2'b01, 2'b10, 0, '{default: 0}};
    tbl[7]  = '{8'h67, 32'h0001_0000, 4'd1, 3'd2, 2'b11, 2'b10, 0, '{default: 0}};
    tbl[8]  = '{8'h68, 32'h0001_0000, 4'd2, 3'd2, 2'b10, 2'b10, 0, '{default: 0}};
    tbl[9]  = '{8'h69, 32'h0001_0002, 4'd1, 3'd2, 2'b10, 2'b10, 0, '{default: 0}};
    tbl[10] = '{8'h6A, 32'h0001_0006, 4'd1, 3'd1, 2'b00, 2'b00, 2, '{14'h1, 14'h1, 14'h0, 14'h0}};
    tbl[11] = '{8'h6B, 32'h0001_0004, 4'd1, 3'd2, 2'b10, 2'b00, 2, '{14'h1, 14'h0, 14'h0, 14'h0}};
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_bid", BID, 0);
    check("rst_mem_we", mem_we, 0);
    ARESET = 0;
    @(negedge ACLK);
    for (int i = 0; i < 12; i++) run_burst(tbl[i]);
    // early WLAST on beat 1 of a 4-beat burst, then a held response
    wq.delete();
    send_aw(8'h33, 32'h0001_0020, 4'd3, 3'd2, 2'b01);
    send_w(32'hB0, 4'hF, 0);
    send_w(32'hB1, 4'hF, 1);
    #1;
    check("early_wlast_wready", WREADY, 0);
    get_b(8'h33, 2'b10, 5);
    ea = '{14'h8, 14'h9, 14'h0, 14'h0};
    check_writes(2, ea);
    // final beat without WLAST
    wq.delete();
    send_aw(8'h44, 32'h0001_0040, 4'd1, 3'd2, 2'b01);
    send_w(32'hC0, 4'hF, 0);
    send_w(32'hC1, 4'hF, 0);
    get_b(8'h44, 2'b10, 0);
    ea = '{14'h10, 14'h11, 14'h0, 14'h0};
    check_writes(2, ea);
    // reset after 2 of 4 beats, with a beat still offered
    wq.delete();
    send_aw(8'h11, 32'h0001_0000, 4'd3, 3'd2, 2'b01);
    send_w(32'hD0, 4'hF, 0);
    send_w(32'hD1, 4'hF, 0);
    WVALID = 1; WDATA = 32'hD2; ARESET = 1;
    #1;
    check("rst_mid_mem_we", mem_we, 0);
    @(negedge ACLK);
    #1;
    check("rst_mid_awready", AWREADY, 0);
    check("rst_mid_wready", WREADY, 0);
    check("rst_mid_bvalid", BVALID, 0);
    check("rst_mid_bresp", BRESP, 0);
    check("rst_mid_bid", BID, 0);
    check("rst_mid_mem_we2", mem_we, 0);
    ARESET = 0; WVALID = 0;
    @(negedge ACLK);
    #1;
    check("post_rst_bvalid", BVALID, 0);
    check("post_rst_mem_we", mem_we, 0);
    check("post_rst_awready", AWREADY, 1);
    @(negedge ACLK);
    run_burst(tbl[0]);
    // FIXED burst with WVALID gaps between beats
    wq.delete();
    send_aw(8'h22, 32'h0001_0000, 4'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      send_w(32'hE0 + i, 4'hF, i == 2);
      if (i < 2) begin
        #1;
        check("gap_mem_we", mem_we, 0);
        @(negedge ACLK);
      end
    end
    get_b(8'h22, 2'b00, 0);
    ea = '{14'h0, 14'h0, 14'h0, 14'h0};
    check_writes(3, ea);
    run_burst(tbl[7]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
